// File: rtl/spi_rx_pkg.sv
// Shared constants, frame field offsets and FSM state type for the SPI serial-to-parallel receiver.
package spi_rx_pkg;

    localparam int FRAME_W  = 16;
    localparam int DATA_W   = 14;
    localparam int CH_W     = 2;
    localparam int NUM_CH   = 1 << CH_W;
    localparam int CNT_W    = $clog2(FRAME_W);

    localparam int CH_MSB   = 15;
    localparam int CH_LSB   = 14;
    localparam int DATA_MSB = 13;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        SHIFT
    } rx_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with optional rising-edge strobe.
module spi_in_sync #(
    parameter int STAGES  = 2,
    parameter bit RISE_EN = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              last_q;
    logic              last_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        last_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = RISE_EN ? (sync_q[STAGES-1] & ~last_q) : 1'b0;

endmodule

// File: rtl/spi_s2p_rx.sv
// SPI mode-0 slave receiver: oversampled, MSB-first {ch, delay} frames out as a one-clk strobe.
// Optional per-channel delay registers are built when SPI_CH_REG_EN is defined.
module spi_s2p_rx
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sck,
    input  logic                     cs,
    input  logic                     mosi,
    output logic [DATA_W-1:0]        rx_data,
    output logic [CH_W-1:0]          rx_ch,
    output logic                     rx_valid,
    output logic                     frame_err,
    output logic                     busy
`ifdef SPI_CH_REG_EN
    ,
    output logic [NUM_CH*DATA_W-1:0] ch_delay
`endif
);

    logic sck_s, sck_rise;
    logic cs_s, cs_rise_unused;
    logic mosi_s, mosi_rise_unused;

    // Equal synchronizer depth keeps mosi aligned with the sck edge that samples it.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b1)) u_sync_sck (
        .clk(clk), .rstn(rstn), .d(sck), .q(sck_s), .rise(sck_rise)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b0)) u_sync_cs (
        .clk(clk), .rstn(rstn), .d(cs), .q(cs_s), .rise(cs_rise_unused)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b0)) u_sync_mosi (
        .clk(clk), .rstn(rstn), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused)
    );

    rx_state_e          state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic [CH_W-1:0]    rx_ch_q, rx_ch_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_ch_d     = rx_ch_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ARM: begin
                if (cs_s) state_d = IDLE;
            end
            IDLE: begin
                if (!cs_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    shreg_d   = {shreg_q[FRAME_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        rx_valid_d = 1'b1;
                        rx_ch_d    = shreg_d[CH_MSB:CH_LSB];
                        rx_data_d  = shreg_d[DATA_MSB:0];
                    end
                end
                // A final bit arriving with cs release wraps the count to 0, so it is not an error.
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_d != '0);
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                end
            end
            default: state_d = ARM;
        endcase

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ARM;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_ch_q     <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_ch_q     <= rx_ch_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_ch     = rx_ch_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

`ifdef SPI_CH_REG_EN
    logic [DATA_W-1:0] ch_reg_q [NUM_CH];
    logic [DATA_W-1:0] ch_reg_d [NUM_CH];

    always_comb begin
        ch_reg_d = ch_reg_q;
        if (rx_valid_q) ch_reg_d[rx_ch_q] = rx_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) ch_reg_q[i] <= '0;
        end else begin
            ch_reg_q <= ch_reg_d;
        end
    end

    always_comb begin
        ch_delay = '0;
        for (int i = 0; i < NUM_CH; i++) ch_delay[i*DATA_W +: DATA_W] = ch_reg_q[i];
    end
`endif

endmodule
